sprite_line_fetch_sched: RTL and testbench

- Per-scanline sprite scheduler for the tiny sprite engine.
- On each line_start it walks the sprite slots in index order and tests each slot for a vertical hit on the current line.
- For every hit it issues a req/ack read to the sprite pattern store for that sprite's row, and latches the returned row into per-slot line registers.
- Sits between the video timing generator (line_start, line_y) and the pixel compositor (row_valid, row_data).

---
 rtl/sprite_line_fetch_sched.sv | 115 +++++++++++
 tb/tb_sprite_line_fetch_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_fetch_sched.sv
// Per-scanline sprite scheduler: scans slots in priority order on line_start,
// fetches the pattern row of every vertically hit sprite into line registers.
module sprite_line_fetch_sched #(
    parameter int NUM_SPR = 4,
    parameter int SPR_H   = 12,
    parameter int SPR_W   = 12,
    parameter int COORD_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       line_start,
    input  logic [COORD_W-1:0]         line_y,
    input  logic [NUM_SPR-1:0]         spr_en,
    input  logic [NUM_SPR*COORD_W-1:0] spr_y,
    output logic                       pat_req,
    output logic [1:0]                 pat_id,
    output logic [3:0]                 pat_row,
    input  logic                       pat_ack,
    input  logic [SPR_W-1:0]           pat_data,
    output logic [NUM_SPR-1:0]         row_valid,
    output logic [NUM_SPR*SPR_W-1:0]   row_data,
    output logic                       busy,
    output logic                       line_done,
    output logic                       overrun
);

    localparam int IW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

    typedef enum logic [1:0] {IDLE, CHECK, FETCH, DONE} state_t;

    state_t                     state_q;
    logic [IW-1:0]              idx_q;
    logic [COORD_W-1:0]         ly_q;
    logic                       pat_req_q;
    logic [1:0]                 pat_id_q;
    logic [3:0]                 pat_row_q;
    logic [NUM_SPR-1:0]         row_valid_q;
    logic [NUM_SPR*SPR_W-1:0]   row_data_q;
    logic                       overrun_q;

    logic [COORD_W-1:0]         dy;
    logic                       hit;
    logic                       last;

    // Modulo subtraction makes sprites straddling the top of the frame wrap.
    always_comb begin
        dy   = ly_q - spr_y[int'(idx_q)*COORD_W +: COORD_W];
        hit  = spr_en[idx_q] && (dy < COORD_W'(SPR_H));
        last = (idx_q == IW'(NUM_SPR-1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            ly_q        <= '0;
            pat_req_q   <= 1'b0;
            pat_id_q    <= '0;
            pat_row_q   <= '0;
            row_valid_q <= '0;
            row_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= line_start && (state_q != IDLE);
            unique case (state_q)
                IDLE: begin
                    if (line_start) begin
                        ly_q        <= line_y;
                        idx_q       <= '0;
                        row_valid_q <= '0;
                        row_data_q  <= '0;
                        state_q     <= CHECK;
                    end
                end
                CHECK: begin
                    if (hit) begin
                        pat_req_q <= 1'b1;
                        pat_id_q  <= 2'(idx_q);
                        pat_row_q <= dy[3:0];
                        state_q   <= FETCH;
                    end else if (last) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                FETCH: begin
                    if (pat_ack) begin
                        row_data_q[int'(idx_q)*SPR_W +: SPR_W] <= pat_data;
                        row_valid_q[idx_q] <= 1'b1;
                        pat_req_q <= 1'b0;
                        if (last) begin
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= CHECK;
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pat_req   = pat_req_q;
    assign pat_id    = pat_id_q;
    assign pat_row   = pat_row_q;
    assign row_valid = row_valid_q;
    assign row_data  = row_data_q;
    assign busy      = (state_q != IDLE);
    assign line_done = (state_q == DONE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sprite_line_fetch_sched.sv
// Directed vector bench for sprite_line_fetch_sched: table of scanlines
// plus hand-written reset sequences.
module tb_sprite_line_fetch_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_start = 1'b0;
    logic [7:0]  line_y = '0;
    logic [3:0]  spr_en = '0;
    logic [31:0] spr_y = '0;
    logic        pat_req;
    logic [1:0]  pat_id;
    logic [3:0]  pat_row;
    logic        pat_ack = 1'b0;
    logic [11:0] pat_data = '0;
    logic [3:0]  row_valid;
    logic [47:0] row_data;
    logic        busy;
    logic        line_done;
    logic        overrun;

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    sprite_line_fetch_sched dut (
        .clk(clk), .rst(rst),
        .line_start(line_start), .line_y(line_y),
        .spr_en(spr_en), .spr_y(spr_y),
        .pat_req(pat_req), .pat_id(pat_id), .pat_row(pat_row),
        .pat_ack(pat_ack), .pat_data(pat_data),
        .row_valid(row_valid), .row_data(row_data),
        .busy(busy), .line_done(line_done), .overrun(overrun)
    );

    typedef struct {
        logic [7:0]  ly;
        logic [3:0]  en;
        logic [31:0] y;
        int          d;
        logic [11:0] pd;
        int          ov_at;
        logic [3:0]  ev;
        logic [15:0] erow;
        int          edone;
        int          eov;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(input logic [7:0] ly, input logic [3:0] en,
                                input logic [31:0] y, input int d,
                                input logic [11:0] pd, input int ov_at,
                                input logic [3:0] ev, input logic [15:0] erow,
                                input int edone, input int eov);
        vec_t v;
        v.ly = ly; v.en = en; v.y = y; v.d = d; v.pd = pd;
        v.ov_at = ov_at; v.ev = ev; v.erow = erow;
        v.edone = edone; v.eov = eov;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic run_line(input vec_t v, input int vi);
        int          n;
        int          reqcyc;
        int          done;
        int          ovc;
        logic [3:0]  fmask;
        logic [15:0] obs_rows;
        logic        stab_err;
        logic [1:0]  cid;
        logic [3:0]  crow;
        logic [47:0] exp_rd;
        string       tag;
        reqcyc = 0; done = -1; ovc = 0;
        fmask = '0; obs_rows = '0; stab_err = 1'b0;
        cid = '0; crow = '0;
        tag = $sformatf("v%0d", vi);
        @(negedge clk);
        line_y = v.ly; spr_en = v.en; spr_y = v.y;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        n = 1;
        while (n <= 100) begin
            if (overrun) ovc++;
            if (pat_req) begin
                reqcyc++;
                if (reqcyc == 1) begin
                    cid = pat_id; crow = pat_row;
                    fmask[pat_id] = 1'b1;
                    obs_rows[pat_id*4 +: 4] = pat_row;
                end else if (pat_id !== cid || pat_row !== crow) begin
                    stab_err = 1'b1;
                end
                pat_ack  = (reqcyc == v.d);
                pat_data = v.pd + 12'(pat_id);
            end else begin
                reqcyc = 0;
                pat_ack = 1'b0;
            end
            line_start = (n == v.ov_at);
            line_y = (n == v.ov_at) ? 8'd0 : v.ly;
            if (line_done) begin
                done = n;
                break;
            end
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        line_start = 1'b0;
        pat_ack = 1'b0;
        if (overrun) ovc++;
        for (int i = 0; i < 4; i++)
            exp_rd[i*12 +: 12] = v.ev[i] ? v.pd + 12'(i) : 12'h000;
        chk({tag, " done_cycle"}, 64'(done), 64'(v.edone));
        chk({tag, " fetch_mask"}, 64'(fmask), 64'(v.ev));
        chk({tag, " pat_rows"}, 64'(obs_rows), 64'(v.erow));
        chk({tag, " req_stable"}, 64'(stab_err), 64'd0);
        chk({tag, " row_valid"}, 64'(row_valid), 64'(v.ev));
        chk({tag, " row_data"}, 64'(row_data), 64'(exp_rd));
        chk({tag, " overrun_cnt"}, 64'(ovc), 64'(v.eov));
        chk({tag, " idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int  n;
        bit  found;
        tbl[0] = mk(8'd20, 4'b0000, 32'h00000000, 1, 12'h000, 0,
                    4'b0000, 16'h0000, 5, 0);
        tbl[1] = mk(8'd15, 4'b0001, 32'h0000000A, 1, 12'hABC, 0,
                    4'b0001, 16'h0005, 6, 0);
        tbl[2] = mk(8'd45, 4'b1111, 32'h3C32281E, 3, 12'h123, 0,
                    4'b0010, 16'h0050, 8, 0);
        tbl[3] = mk(8'd4, 4'b0001, 32'h000000FA, 1, 12'h5A5, 0,
                    4'b0001, 16'h000A, 6, 0);
        tbl[4] = mk(8'd11, 4'b0010, 32'h00000000, 1, 12'h777, 0,
                    4'b0010, 16'h00B0, 6, 0);
        tbl[5] = mk(8'd12, 4'b0100, 32'h00000000, 1, 12'h000, 0,
                    4'b0000, 16'h0000, 5, 0);
        tbl[6] = mk(8'd15, 4'b1110, 32'h0A0A0A0A, 2, 12'h100, 0,
                    4'b1110, 16'h5550, 11, 0);
        tbl[7] = mk(8'd7, 4'b1111, 32'h07070707, 1, 12'h200, 0,
                    4'b1111, 16'h0000, 9, 0);
        tbl[8] = mk(8'd45, 4'b1111, 32'h3C32281E, 3, 12'h321, 2,
                    4'b0010, 16'h0050, 8, 1);
        tbl[9] = mk(8'd20, 4'b0000, 32'h00000000, 1, 12'h000, 5,
                    4'b0000, 16'h0000, 5, 1);

        #1;
        chk("rst pat_req", 64'(pat_req), 64'd0);
        chk("rst pat_id_row", 64'({pat_id, pat_row}), 64'd0);
        chk("rst row_valid", 64'(row_valid), 64'd0);
        chk("rst row_data", 64'(row_data), 64'd0);
        chk("rst flags", 64'({busy, line_done, overrun}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_line(tbl[i], i);

        // Reset while slot 1's request is outstanding and slot 0 is filled.
        @(negedge clk);
        line_y = 8'd15; spr_en = 4'b0011; spr_y = 32'h00000A0A;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        found = 1'b0;
        n = 0;
        while (n < 50 && !found) begin
            if (pat_req && pat_id == 2'd1) begin
                found = 1'b1;
                pat_ack = 1'b0;
            end else begin
                pat_ack = pat_req && (pat_id == 2'd0);
                pat_data = 12'hF0F;
                @(negedge clk);
                n++;
            end
        end
        chk("midrst req_seen", 64'(found), 64'd1);
        chk("midrst pre_valid", 64'(row_valid), 64'b0001);
        #2 rst = 1'b1;
        #1;
        chk("midrst pat_req", 64'(pat_req), 64'd0);
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst row_valid", 64'(row_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_line(tbl[1], 100);
        run_line(tbl[2], 101);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule
